// File: rtl/rmii_rx.sv
// rmii_rx: RMII receive front end in the 50 MHz reference-clock domain.
// It hunts for the preamble and SFD, then packs LSB-first dibits into bytes.
// Bytes are emitted one byte late so the last byte of a frame can carry eof.
// Optional build macro RMII_RX_CRC_EN: adds a CRC-32 residue check of the FCS.
// When the check fails it also sets frame_err on the eof byte.
//
// Output handshake: data_valid is a one-cycle strobe. data/sof/eof/frame_err
// qualify it in the same cycle. There is no ready and no backpressure, so the
// consumer must take every strobe.
module rmii_rx #(
    parameter int MIN_PRE_DIBITS  = 4,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic [1:0] rxd,
    input  logic       crs_dv,
    input  logic       rx_er,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       sof,
    output logic       eof,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [4:0]  MIN_PRE   = 5'(MIN_PRE_DIBITS);
    localparam logic [10:0] MAX_BYTES = 11'(MAX_FRAME_BYTES);

    state_t      state, state_n;
    logic [4:0]  pre_cnt, pre_cnt_n;
    logic [1:0]  sym_cnt, sym_cnt_n;
    logic [10:0] byte_cnt, byte_cnt_n;
    logic [5:0]  asm_q, asm_n;        // low three dibits of the byte in progress
    logic [7:0]  hold_q, hold_n;      // last completed byte, not yet emitted
    logic        hold_vld, hold_vld_n;
    logic        sof_pend, sof_pend_n;
    logic        err_q, err_n;        // sticky rx_er seen during this frame
    logic        low_seen, low_seen_n;
    logic [7:0]  data_n;
    logic        dv_n, sof_n, eof_n, ferr_n;
    logic [7:0]  full_byte;
    logic        err_now;
    logic        crc_bad;

`ifdef RMII_RX_CRC_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [31:0] crc_q, crc_n;

    // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ d[i]}});
        end
        return c;
    endfunction

    // A good frame, FCS included, leaves the fixed residue in the register.
    assign crc_bad = (crc_q != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    // Next-state and next-output logic for the receive FSM and its datapath.
    always_comb begin
        state_n    = state;
        pre_cnt_n  = pre_cnt;
        sym_cnt_n  = sym_cnt;
        byte_cnt_n = byte_cnt;
        asm_n      = asm_q;
        hold_n     = hold_q;
        hold_vld_n = hold_vld;
        sof_pend_n = sof_pend;
        err_n      = err_q;
        low_seen_n = low_seen;
        data_n     = data;
        dv_n       = 1'b0;
        sof_n      = 1'b0;
        eof_n      = 1'b0;
        ferr_n     = 1'b0;
`ifdef RMII_RX_CRC_EN
        crc_n      = crc_q;
`endif
        full_byte  = {rxd, asm_q};
        err_now    = err_q | rx_er;

        case (state)
            IDLE: begin
                if (crs_dv) begin
                    if (rxd == 2'b01) begin
                        state_n   = PREAMBLE;
                        pre_cnt_n = 5'd1;
                    end else begin
                        state_n    = DROP;
                        low_seen_n = 1'b0;
                    end
                end
            end

            PREAMBLE: begin
                if (!crs_dv) begin
                    state_n = IDLE;
                end else if (rxd == 2'b01) begin
                    if (pre_cnt != 5'd31) pre_cnt_n = pre_cnt + 5'd1;
                end else if (rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
                    state_n    = DATA;
                    sym_cnt_n  = 2'd0;
                    byte_cnt_n = 11'd0;
                    asm_n      = 6'd0;
                    err_n      = 1'b0;
                    hold_vld_n = 1'b0;
                    sof_pend_n = 1'b1;
`ifdef RMII_RX_CRC_EN
                    crc_n      = 32'hFFFFFFFF;
`endif
                end else begin
                    state_n    = DROP;
                    low_seen_n = 1'b0;
                end
            end

            DATA: begin
                err_n = err_now;
                if (!crs_dv && sym_cnt[0]) begin
                    // End of carrier. crs_dv low on an even dibit is only PHY toggling.
                    if (hold_vld) begin
                        dv_n   = 1'b1;
                        data_n = hold_q;
                        sof_n  = sof_pend;
                        eof_n  = 1'b1;
                        ferr_n = (sym_cnt == 2'd3) | err_now | crc_bad;
                    end
                    hold_vld_n = 1'b0;
                    sof_pend_n = 1'b0;
                    state_n    = IDLE;
                end else begin
                    sym_cnt_n = sym_cnt + 2'd1;
                    case (sym_cnt)
                        2'd0:    asm_n[1:0] = rxd;
                        2'd1:    asm_n[3:2] = rxd;
                        2'd2:    asm_n[5:4] = rxd;
                        default: begin
                            if (byte_cnt == MAX_BYTES) begin
                                // One byte too many: close the frame as bad and ignore the rest.
                                dv_n       = 1'b1;
                                data_n     = hold_q;
                                sof_n      = sof_pend;
                                eof_n      = 1'b1;
                                ferr_n     = 1'b1;
                                hold_vld_n = 1'b0;
                                sof_pend_n = 1'b0;
                                state_n    = DROP;
                                low_seen_n = 1'b0;
                            end else begin
                                if (hold_vld) begin
                                    dv_n       = 1'b1;
                                    data_n     = hold_q;
                                    sof_n      = sof_pend;
                                    sof_pend_n = 1'b0;
                                end
                                hold_n     = full_byte;
                                hold_vld_n = 1'b1;
                                byte_cnt_n = byte_cnt + 11'd1;
`ifdef RMII_RX_CRC_EN
                                crc_n      = crc_byte(crc_q, full_byte);
`endif
                            end
                        end
                    endcase
                end
            end

            default: begin
                // DROP: wait for two consecutive low crs_dv cycles.
                if (!crs_dv) begin
                    if (low_seen) state_n = IDLE;
                    low_seen_n = 1'b1;
                end else begin
                    low_seen_n = 1'b0;
                end
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre_cnt    <= 5'd0;
            sym_cnt    <= 2'd0;
            byte_cnt   <= 11'd0;
            asm_q      <= 6'd0;
            hold_q     <= 8'd0;
            hold_vld   <= 1'b0;
            sof_pend   <= 1'b0;
            err_q      <= 1'b0;
            low_seen   <= 1'b0;
            data       <= 8'd0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef RMII_RX_CRC_EN
            crc_q      <= 32'hFFFFFFFF;
`endif
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            sym_cnt    <= sym_cnt_n;
            byte_cnt   <= byte_cnt_n;
            asm_q      <= asm_n;
            hold_q     <= hold_n;
            hold_vld   <= hold_vld_n;
            sof_pend   <= sof_pend_n;
            err_q      <= err_n;
            low_seen   <= low_seen_n;
            data       <= data_n;
            data_valid <= dv_n;
            sof        <= sof_n;
            eof        <= eof_n;
            frame_err  <= ferr_n;
            busy       <= (state_n != IDLE);
`ifdef RMII_RX_CRC_EN
            crc_q      <= crc_n;
`endif
        end
    end

endmodule

// File: tb/tb_rmii_rx.sv
// tb_rmii_rx: directed bench for rmii_rx in its default build.
// The default instance and a MAX_FRAME_BYTES=4 instance share the inputs.
// Each instance has its own expected-strobe queue.
module tb_rmii_rx;

    logic       clk50 = 1'b0;
    logic       rst_n;
    logic [1:0] rxd;
    logic       crs_dv;
    logic       rx_er;

    logic [7:0] data,   data_s;
    logic       data_valid, data_valid_s;
    logic       sof,    sof_s;
    logic       eof,    eof_s;
    logic       frame_err, frame_err_s;
    logic       busy,   busy_s;

    rmii_rx dut (
        .clk50(clk50), .rst_n(rst_n), .rxd(rxd), .crs_dv(crs_dv), .rx_er(rx_er),
        .data(data), .data_valid(data_valid), .sof(sof), .eof(eof),
        .frame_err(frame_err), .busy(busy)
    );

    rmii_rx #(.MAX_FRAME_BYTES(4)) dut_small (
        .clk50(clk50), .rst_n(rst_n), .rxd(rxd), .crs_dv(crs_dv), .rx_er(rx_er),
        .data(data_s), .data_valid(data_valid_s), .sof(sof_s), .eof(eof_s),
        .frame_err(frame_err_s), .busy(busy_s)
    );

    // Clock and reset
    always #10 clk50 = ~clk50;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries: {frame_err, eof, sof, data}
    logic [10:0] exp_q[$];
    logic [10:0] exp_s_q[$];
    logic        prev_dv;
    logic        prev_dv_s;

    function automatic logic [10:0] ex(input logic ferr, input logic e, input logic s, input logic [7:0] d);
        return {ferr, e, s, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_both(input logic [10:0] e);
        exp_q.push_back(e);
        exp_s_q.push_back(e);
    endtask

    // Compare any strobe from either instance against the head of its queue.
    task automatic sample();
        logic [10:0] e;
        if (data_valid) begin
            check("dut_spacing", 32'(prev_dv), 32'd0);
            check("dut_strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dut_strobe", 32'({frame_err, eof, sof, data}), 32'(e));
            end
        end
        if (data_valid_s) begin
            check("small_spacing", 32'(prev_dv_s), 32'd0);
            check("small_strobe_expected", 32'(exp_s_q.size() > 0), 32'd1);
            if (exp_s_q.size() > 0) begin
                e = exp_s_q.pop_front();
                check("small_strobe", 32'({frame_err_s, eof_s, sof_s, data_s}), 32'(e));
            end
        end
        prev_dv   = data_valid;
        prev_dv_s = data_valid_s;
    endtask

    // Driver: one RMII cycle of input, then the output sample for that cycle.
    task automatic cycle(input logic [1:0] d, input logic dv, input logic er);
        @(posedge clk50);
        #1;
        rxd    = d;
        crs_dv = dv;
        rx_er  = er;
        @(negedge clk50);
        sample();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] dvpat, input logic er);
        for (int i = 0; i < 4; i++) cycle(b[2*i +: 2], dvpat[i], er);
    endtask

    // 7 x 0x55 then 0xD5: 31 dibits of 01, then the 11 SFD dibit.
    task automatic send_pre();
        for (int i = 0; i < 31; i++) cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_dut_q"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_small_q"}, 32'(exp_s_q.size()), 32'd0);
    endtask

    initial begin
        prev_dv   = 1'b0;
        prev_dv_s = 1'b0;
        rst_n     = 1'b0;
        rxd       = 2'b00;
        crs_dv    = 1'b0;
        rx_er     = 1'b0;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_eof", 32'(eof), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_busy_small", 32'(busy_s), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Basic 3-byte frame ending at sym_cnt 0
        push_both(ex(1'b0, 1'b0, 1'b1, 8'h01));
        push_both(ex(1'b0, 1'b0, 1'b0, 8'h02));
        push_both(ex(1'b0, 1'b1, 1'b0, 8'h03));
        send_pre();
        check("busy_in_frame", 32'(busy), 32'd1);
        send_byte(8'h01, 4'hF, 1'b0);
        send_byte(8'h02, 4'hF, 1'b0);
        send_byte(8'h03, 4'hF, 1'b0);
        idle(5);
        check("basic_idle_busy", 32'(busy), 32'd0);
        check_drained("basic");

        // crs_dv toggling low on even dibits of the last two bytes
        push_both(ex(1'b0, 1'b0, 1'b1, 8'h01));
        push_both(ex(1'b0, 1'b0, 1'b0, 8'h02));
        push_both(ex(1'b0, 1'b1, 1'b0, 8'h03));
        send_pre();
        send_byte(8'h01, 4'hF, 1'b0);
        send_byte(8'h02, 4'b1010, 1'b0);
        send_byte(8'h03, 4'b1010, 1'b0);
        idle(5);
        check_drained("toggle");

        // End detected at sym_cnt 3: alignment error on the last full byte
        push_both(ex(1'b0, 1'b0, 1'b1, 8'h01));
        push_both(ex(1'b0, 1'b0, 1'b0, 8'h02));
        push_both(ex(1'b1, 1'b1, 1'b0, 8'h03));
        send_pre();
        send_byte(8'h01, 4'hF, 1'b0);
        send_byte(8'h02, 4'hF, 1'b0);
        send_byte(8'h03, 4'hF, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        idle(5);
        check_drained("align");

        // Single-byte frame carries both sof and eof; empty frame emits nothing
        push_both(ex(1'b0, 1'b1, 1'b1, 8'hA5));
        send_pre();
        send_byte(8'hA5, 4'hF, 1'b0);
        idle(5);
        send_pre();
        idle(5);
        check_drained("single_empty");

        // rx_er pulse during the second byte flags the eof byte only
        push_both(ex(1'b0, 1'b0, 1'b1, 8'h31));
        push_both(ex(1'b0, 1'b0, 1'b0, 8'h32));
        push_both(ex(1'b1, 1'b1, 1'b0, 8'h33));
        send_pre();
        send_byte(8'h31, 4'hF, 1'b0);
        send_byte(8'h32, 4'hF, 1'b1);
        send_byte(8'h33, 4'hF, 1'b0);
        idle(5);
        check_drained("rx_er");

        // Bad start dibit: DROP swallows a whole frame until two low cycles
        cycle(2'b10, 1'b1, 1'b0);
        send_pre();
        send_byte(8'h11, 4'hF, 1'b0);
        send_byte(8'h22, 4'hF, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        send_byte(8'h33, 4'hF, 1'b0);
        check("drop_busy", 32'(busy), 32'd1);
        check("drop_busy_small", 32'(busy_s), 32'd1);
        idle(3);
        check("drop_exit_busy", 32'(busy), 32'd0);
        push_both(ex(1'b0, 1'b0, 1'b1, 8'h44));
        push_both(ex(1'b0, 1'b1, 1'b0, 8'h55));
        send_pre();
        send_byte(8'h44, 4'hF, 1'b0);
        send_byte(8'h55, 4'hF, 1'b0);
        idle(5);
        check_drained("drop");

        // Six-byte frame: full on the default instance, overlong on the small one
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex(1'b0, 1'(i == 5), 1'(i == 0), 8'(8'h10 + i)));
        end
        for (int i = 0; i < 4; i++) begin
            exp_s_q.push_back(ex(1'(i == 3), 1'(i == 3), 1'(i == 0), 8'(8'h10 + i)));
        end
        send_pre();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 4'hF, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        check("overlong_busy_a", 32'(busy_s), 32'd1);
        cycle(2'b00, 1'b0, 1'b0);
        check("overlong_busy_b", 32'(busy_s), 32'd1);
        cycle(2'b00, 1'b0, 1'b0);
        check("overlong_busy_c", 32'(busy_s), 32'd0);
        idle(4);
        check_drained("overlong");

        // Reset mid-frame: no eof, outputs drop at once, restart into DROP
        send_pre();
        send_byte(8'h66, 4'hF, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0);
        check("midrst_busy_before", 32'(busy), 32'd1);
        @(posedge clk50);
        #1;
        rst_n  = 1'b0;
        rxd    = 2'b10;
        crs_dv = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        rst_n     = 1'b1;
        prev_dv   = 1'b0;
        prev_dv_s = 1'b0;
        cycle(2'b10, 1'b1, 1'b0);
        check("midrst_drop_busy", 32'(busy), 32'd1);
        idle(4);
        check("midrst_end_busy", 32'(busy), 32'd0);
        check_drained("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rmii_rx.md
# rmii_rx

RMII receive MAC front end for the 50 MHz reference-clock domain. It samples `rxd`/`crs_dv` from the PHY, detects preamble and SFD, and reassembles LSB-first dibits into bytes. It emits a byte stream with start/end-of-frame markers and an error flag. It is the receive-side counterpart of the RMII transmitter and feeds the packet parser / command decoder.

## Interface
Parameters:
- `MIN_PRE_DIBITS`, default 4: minimum count of `01` preamble dibits required before the SFD dibit `11`. Range 1..31.
- `MAX_FRAME_BYTES`, default 1522: maximum number of bytes after the SFD. This includes the FCS. Width of the length counter is 11 bits.

Ports:
- `clk50` in 1: 50 MHz RMII reference clock. The single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 2: RMII receive dibit, LSB-first.
- `crs_dv` in 1: RMII carrier-sense/data-valid. May toggle at frame end.
- `rx_er` in 1: PHY receive error.
- `data` out 8: received byte.
- `data_valid` out 1: one-cycle strobe; `data`/`sof`/`eof`/`frame_err` are valid this cycle.
- `sof` out 1: first byte after the SFD.
- `eof` out 1: last byte of the frame.
- `frame_err` out 1: frame is bad. Meaningful only with `eof`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- All outputs reset to 0. State resets to IDLE, and all counters and the held-byte register clear.
- States are IDLE, PREAMBLE, DATA and DROP. Dibit order is LSB first; `sym_cnt` 0..3 maps to byte bits [1:0], [3:2], [5:4], [7:6].
- **IDLE**
  - `crs_dv`=1 and `rxd`=01 → PREAMBLE, with `pre_cnt`=1.
  - `crs_dv`=1 and any other `rxd` → DROP.
- **PREAMBLE**
  - `crs_dv`=0 → IDLE.
  - `rxd`=01 → `pre_cnt`++ (saturates at 31).
  - `rxd`=11 and `pre_cnt` ≥ `MIN_PRE_DIBITS` → DATA, with `sym_cnt`=0, `byte_cnt`=0, errors cleared.
  - Any other case → DROP.
- **DATA**
  - Each cycle shifts `rxd` into the assembly register at `sym_cnt`, then increments `sym_cnt`.
  - On `sym_cnt`=3, the completed byte goes into a one-byte hold register. The previously held byte, if any, is emitted with `eof`=0, and `byte_cnt`++.
  - `crs_dv`=0 at even `sym_cnt` (0, 2): the dibit is still accepted. This tolerates PHY toggling on the first dibit of a nibble.
  - `crs_dv`=0 at odd `sym_cnt` (1, 3) means end of frame:
    - The held byte, if present, is emitted with `eof`=1.
    - The partial byte is discarded.
    - `sym_cnt`=3 at end sets an alignment error.
    - If no byte is held (SFD followed immediately by end), nothing is emitted.
    - Next state is IDLE.
  - `rx_er`=1 in DATA sets a sticky error, reported on `eof`.
  - Completing byte `MAX_FRAME_BYTES`+1 emits the held byte with `eof`=1 and `frame_err`=1, then → DROP.
- **DROP**
  - Outputs nothing.
  - `crs_dv`=0 on two consecutive cycles → IDLE.
- `frame_err` = alignment OR `rx_er` OR overlong OR (CRC fail, if compiled in).
- `sof`=1 on the first emitted byte of a frame only. A single-byte frame has `sof`=`eof`=1.
- `busy` = (state ≠ IDLE), registered.

## Timing
- Outputs are registered.
- A byte completing at cycle t is emitted at t+4, when the next byte completes, or at t+2 if the end is detected at `sym_cnt`=1.
- `data_valid` is never high on consecutive cycles. The minimum spacing is 4 cycles, except the `eof` byte, which may follow the preceding strobe by 2.
- There is no backpressure; the consumer must accept every strobe.
- Reset asserted mid-frame: outputs drop immediately and no `eof` is emitted. After release with `crs_dv` high on a non-`01` dibit → DROP.

## Configuration
- `RMII_RX_CRC_EN` defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is computed over all bytes after the SFD, including the FCS.
  - At end of frame, a residue ≠ 0xDEBB20E3 (unreflected 0xC704DD7B) sets `frame_err` on the `eof` byte.
- Not defined: no CRC logic, and `frame_err` covers only alignment, `rx_er` and overlong. The FCS bytes are passed through in both cases.

## Test plan
- 7×0x55, 0xD5, then 0x01 0x02 0x03, `crs_dv` falling at `sym_cnt`=0 (CRC macro off) → three strobes: 0x01 with `sof`, 0x02, 0x03 with `eof`, `frame_err`=0.
- Same frame, with `crs_dv` toggling (low on `sym_cnt` 0/2, high on 1/3) during the last two bytes → identical output, no early `eof`.
- Frame ending with `crs_dv` low first at `sym_cnt`=2 (end detected at 3) → last full byte has `eof`=1, `frame_err`=1.
- `crs_dv` high with `rxd`=10, then valid preamble without `crs_dv` dropping for two cycles → no strobes. After two low cycles, the next valid frame is received normally.
- `MAX_FRAME_BYTES`=4, 6-byte frame → strobes for bytes 1–4, byte 4 with `eof`=1 and `frame_err`=1, nothing further, `busy` until `crs_dv` is low for 2 cycles.
- With `RMII_RX_CRC_EN`: 60-byte payload plus correct FCS → `eof` with `frame_err`=0. One payload bit flipped → `frame_err`=1. `rx_er` pulsed mid-frame → `frame_err`=1.
